// File: rtl/adc_avg_packer.sv
// Averages 2^AVG_LOG2 eight-channel ADC frames and streams each average set as an
// 11-word packet (header, count, 8 channels, checksum) over a valid/ready port.

module adc_avg_lane #(
  parameter int AVG_LOG2 = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        smp,
  input  logic        last,
  input  logic [15:0] val,
  output logic [15:0] avg
);
  localparam int AW = 16 + AVG_LOG2;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sum;
  logic        [AW-1:0] shifted;

  assign sum     = acc + AW'($signed(val));
  assign shifted = sum >>> AVG_LOG2;
  assign avg     = shifted[15:0];

  always_ff @(posedge Clk) begin
    if (Rst)      acc <= '0;
    else if (smp) acc <= last ? '0 : sum;
  end
endmodule

module adc_avg_packer #(
  parameter int          AVG_LOG2 = 2,
  parameter logic [15:0] HEADER   = 16'hA5A5
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Sample_vld,
  input  logic [15:0] Value1,
  input  logic [15:0] Value2,
  input  logic [15:0] Value3,
  input  logic [15:0] Value4,
  input  logic [15:0] Value5,
  input  logic [15:0] Value6,
  input  logic [15:0] Value7,
  input  logic [15:0] Value8,
  output logic [15:0] Dout,
  output logic        Dout_vld,
  input  logic        Dout_rdy,
  output logic [7:0]  Frame_cnt,
  output logic        Overrun
);
  localparam int NUM_LANES = 8;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_CNT  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;

  logic [NUM_LANES-1:0][15:0] vals, avg, tx_buf, pend_buf, ld_src;
  logic [CW-1:0] frm;
  logic          last, done;
  logic [2:0]    state, idx;
  logic          pend_full;
  logic [7:0]    cnt_byte;
  logic [15:0]   csum, ld_csum;
  logic          fire, csum_fire, tx_free, ld_pend, ld_avg, ld, to_pend, drop;

  assign vals = {Value8, Value7, Value6, Value5, Value4, Value3, Value2, Value1};

  // With AVG_LOG2 == 0 the counter is pinned at LAST, so every strobe completes.
  assign last = (frm == LAST);
  assign done = Sample_vld & last;

  always_ff @(posedge Clk) begin
    if (Rst)             frm <= '0;
    else if (Sample_vld) frm <= last ? '0 : frm + CW'(1);
  end

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      adc_avg_lane #(.AVG_LOG2(AVG_LOG2)) u_lane (
        .Clk  (Clk),
        .Rst  (Rst),
        .smp  (Sample_vld),
        .last (last),
        .val  (vals[g]),
        .avg  (avg[g])
      );
    end
  endgenerate

  assign fire      = Dout_vld & Dout_rdy;
  assign csum_fire = (state == S_CSUM) & fire;
  assign tx_free   = (state == S_IDLE) | csum_fire;
  // Pending is only ever full while TX is busy, so ld_pend fires on the CSUM handshake.
  assign ld_pend   = tx_free & pend_full;
  assign ld_avg    = tx_free & ~pend_full & done;
  assign ld        = ld_pend | ld_avg;
  // A pending slot being drained this edge can take a new average in the same edge.
  assign to_pend   = done & ~ld_avg & (~pend_full | ld_pend);
  assign drop      = done & ~ld_avg & pend_full & ~ld_pend;
  assign ld_src    = ld_pend ? pend_buf : avg;

  always_comb begin
    ld_csum = HEADER + {Frame_cnt, 8'h08};
    for (int i = 0; i < NUM_LANES; i++) ld_csum = ld_csum + ld_src[i];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      pend_full <= 1'b0;
      Frame_cnt <= '0;
      Overrun   <= 1'b0;
      cnt_byte  <= '0;
      csum      <= '0;
      tx_buf    <= '0;
      pend_buf  <= '0;
    end else begin
      if (ld) begin
        tx_buf    <= ld_src;
        cnt_byte  <= Frame_cnt;
        csum      <= ld_csum;
        Frame_cnt <= Frame_cnt + 8'd1;
      end
      if (to_pend) begin
        pend_buf  <= avg;
        pend_full <= 1'b1;
      end else if (ld_pend) begin
        pend_full <= 1'b0;
      end
      if (drop) Overrun <= 1'b1;

      case (state)
        S_IDLE: if (ld) state <= S_HDR;
        S_HDR:  if (fire) state <= S_CNT;
        S_CNT:  if (fire) begin
          state <= S_DATA;
          idx   <= '0;
        end
        S_DATA: if (fire) begin
          if (idx == 3'd7) state <= S_CSUM;
          else             idx   <= idx + 3'd1;
        end
        S_CSUM: if (fire) state <= ld ? S_HDR : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output word is a pure function of state, so it cannot move while stalled.
  always_comb begin
    Dout = 16'h0000;
    case (state)
      S_HDR:  Dout = HEADER;
      S_CNT:  Dout = {cnt_byte, 8'h08};
      S_DATA: Dout = tx_buf[idx];
      S_CSUM: Dout = csum;
      default: Dout = 16'h0000;
    endcase
  end

  assign Dout_vld = (state != S_IDLE);
endmodule

// File: doc/adc_avg_packer.md
ADC_AVG_PACKER -- requirements
Module: adc_avg_packer

Interface
REQ-001 Parameter AVG_LOG2, default 2, log2 of frames averaged per packet (legal 0..4).
REQ-002 Parameter HEADER, default 16'hA5A5, first word of every packet.
REQ-003 Clk  input  1  single system clock (100 MHz); all logic on rising edge.
REQ-004 Rst  input  1  synchronous, active-high reset.
REQ-005 Sample_vld  input  1  one-cycle strobe; Value1..Value8 hold a new conversion frame this cycle.
REQ-006 Value1..Value8  input  16 each  signed two's-complement channel samples from the AD7609 driver.
REQ-007 Dout  output  16  packet word.
REQ-008 Dout_vld  output  1  Dout holds a valid word.
REQ-009 Dout_rdy  input  1  consumer accepts the word.
REQ-010 Frame_cnt  output  8  number of packets loaded for transmit, mod 256.
REQ-011 Overrun  output  1  sticky flag: an averaged frame was dropped.

Function
REQ-012 Eight signed accumulators, width 16+AVG_LOG2, plus a frame counter of AVG_LOG2 bits, SHALL sum Value1..Value8 on each Sample_vld.
REQ-013 On the 2^AVG_LOG2-th Sample_vld, averages SHALL be (acc + Value) >>> AVG_LOG2 (arithmetic shift, rounding toward minus infinity), truncated to 16 bits; accumulators and frame counter SHALL clear in that same edge.
REQ-014 Completed averages SHALL go to the TX buffer if TX is IDLE; otherwise to the single pending buffer if empty; otherwise dropped, with Overrun set.
REQ-015 Dropped frames SHALL NOT increment Frame_cnt; Frame_cnt SHALL increment on each load into the TX buffer, wrapping 255->0.
REQ-016 Packet SHALL be 11 words: HEADER; {Frame_cnt value at load, 8'h08}; channel 1..8 averages; checksum = sum of words 0..9 mod 2^16.
REQ-017 TX FSM states: IDLE, HDR, CNT, DATA (index 0..7), CSUM; each state advances only on Dout_vld && Dout_rdy.
REQ-018 Dout_vld SHALL rise in the cycle after the edge that loads the TX buffer (1 cycle after the completing Sample_vld).
REQ-019 While Dout_vld=1 and Dout_rdy=0, Dout SHALL remain stable.
REQ-020 After the CSUM handshake: if pending is full, its content SHALL load into TX and HDR start in the next cycle with no idle gap; otherwise FSM returns to IDLE and Dout_vld=0.
REQ-021 A completed average arriving in the same cycle as the CSUM handshake with pending empty SHALL load directly into TX.
REQ-022 Sample_vld SHALL continue to be accumulated regardless of TX state or backpressure.
REQ-023 With AVG_LOG2=0, every Sample_vld SHALL complete a frame.

Reset
REQ-024 When Rst=1 at a rising edge: accumulators, frame counter, pending-full flag and Frame_cnt clear to 0; FSM goes to IDLE; Dout=0; Dout_vld=0; Overrun=0.
REQ-025 Reset mid-packet SHALL abort the packet; no partial word is presented after Rst deasserts.
REQ-026 Sample_vld coincident with Rst SHALL be ignored.
REQ-027 Overrun SHALL clear only through Rst.

Verification
REQ-028 AVG_LOG2=2, Dout_rdy=1, four frames with all channels 100,102,104,106 -> packet A5A5, 0008, eight words 0067, checksum A8E5; Frame_cnt=1.
REQ-029 Four frames with all channels -1,-2,-2,-2 -> channel words FFFE (-7>>>2=-2).
REQ-030 Dout_rdy low for 5 cycles while channel-3 word is presented -> Dout and Dout_vld stay constant; the packet resumes with no lost or duplicated word.
REQ-031 Dout_rdy=0 permanently, 3 averaging periods -> first frame held in TX, second in pending, third dropped; Overrun=1; Frame_cnt=1; then Dout_rdy=1 -> two packets back-to-back with count bytes 00 and 01, and Frame_cnt=2.
REQ-032 Rst pulse during word 5 of a packet -> Dout_vld=0 the cycle after; the next four frames produce a packet with count byte 00.
REQ-033 256+1 packets, Dout_rdy=1 -> count byte wraps FF->00; checksum correct on every packet.
